// File: rtl/modinv_sched_pkg.sv
// Shared op codes, FSM state encoding and iteration-bound helpers for the modinv helper scheduler.
package modinv_sched_pkg;

  localparam int DEF_OPERAND_NUM_BITS = 256;
  localparam int MAX_ITER             = 2 * DEF_OPERAND_NUM_BITS;

  typedef enum logic [2:0] {
    OP_INIT   = 3'd0,
    OP_SHR_U  = 3'd1,
    OP_SHR_V  = 3'd2,
    OP_SUB_UV = 3'd3,
    OP_SUB_VU = 3'd4,
    OP_REDUCE = 3'd5
  } op_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISSUE      = 3'd1,
    ST_ARM        = 3'd2,
    ST_WAIT       = 3'd3,
    ST_DECIDE     = 3'd4,
    ST_RED_DECIDE = 3'd5
  } state_t;

  function automatic int max_iter(input int operand_bits);
    return 2 * operand_bits;
  endfunction

endpackage

// File: rtl/modinv_sched_kcnt.sv
// Saturating up/down iteration counter (k); clear wins, then inc, then dec. Registered zero/max flags.
module modinv_sched_kcnt #(
  parameter int W   = 10,
  parameter int MAX = 512
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_cnt,
  output logic         o_zero,
  output logic         o_max
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] r_cnt;
  logic         r_zero;
  logic         r_max;
  logic [W-1:0] w_cnt_nxt;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = '0;
    end else if (i_inc && (r_cnt != MAX_V)) begin
      w_cnt_nxt = r_cnt + 1'b1;
    end else if (i_dec && (r_cnt != '0)) begin
      w_cnt_nxt = r_cnt - 1'b1;
    end
  end

  // Flags are registered alongside the count so they never lag it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_zero <= 1'b1;
      r_max  <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_zero <= (w_cnt_nxt == '0);
      r_max  <= (w_cnt_nxt == MAX_V);
    end
  end

  assign o_cnt  = r_cnt;
  assign o_zero = r_zero;
  assign o_max  = r_max;

endmodule

// File: rtl/modinv_helper_scheduler.sv
// Almost-inverse helper sequencer: INIT, flag-driven loop, k REDUCE passes; 4 cycles + helper latency per op,
// waits on helper_rdy, ignores ena while busy. Optional perf counters under MODINV_SCHED_PERF_EN.
module modinv_helper_scheduler
  import modinv_sched_pkg::*;
#(
  parameter int OPERAND_NUM_BITS = 256,
  parameter int K_CNT_BITS       = $clog2(2 * OPERAND_NUM_BITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  output logic                  rdy,
  output logic                  err,
  input  logic                  u_is_even,
  input  logic                  v_is_even,
  input  logic                  u_gt_v,
  input  logic                  v_is_one,
  output logic                  helper_ena,
  output logic [2:0]            helper_sel,
  input  logic                  helper_rdy,
  output logic [K_CNT_BITS-1:0] k_cnt,
  output logic                  k_is_nul
`ifdef MODINV_SCHED_PERF_EN
  ,
  output logic [31:0]           perf_cycles,
  output logic [15:0]           perf_ops
`endif
);

  localparam int MAX_ITER_P = max_iter(OPERAND_NUM_BITS);

  state_t r_state;
  state_t w_state_nxt;
  op_t    r_sel;
  op_t    w_sel_nxt;
  logic   r_rdy;
  logic   r_err;
  logic   r_ena;
  logic   w_err_nxt;
  logic   w_k_clr;
  logic   w_k_inc;
  logic   w_k_dec;
  logic   w_k_zero;
  logic   w_k_max;
  logic   w_start;

  modinv_sched_kcnt #(
    .W   (K_CNT_BITS),
    .MAX (MAX_ITER_P)
  ) u_kcnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_k_clr),
    .i_inc  (w_k_inc),
    .i_dec  (w_k_dec),
    .o_cnt  (k_cnt),
    .o_zero (w_k_zero),
    .o_max  (w_k_max)
  );

  assign w_start = (r_state == ST_IDLE) && ena;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:       if (ena) w_state_nxt = ST_ISSUE;
      ST_ISSUE:      w_state_nxt = ST_ARM;
      ST_ARM:        w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (helper_rdy) begin
          w_state_nxt = (r_sel == OP_REDUCE) ? ST_RED_DECIDE : ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        if (v_is_one)     w_state_nxt = ST_RED_DECIDE;
        else if (w_k_max) w_state_nxt = ST_IDLE;
        else              w_state_nxt = ST_ISSUE;
      end
      ST_RED_DECIDE: w_state_nxt = w_k_zero ? ST_IDLE : ST_ISSUE;
      default:       w_state_nxt = ST_IDLE;
    endcase
  end

  // Op choice follows the almost-inverse priority: shift evens first, then subtract smaller from larger.
  always_comb begin
    w_sel_nxt = r_sel;
    w_err_nxt = r_err;
    w_k_clr   = 1'b0;
    w_k_inc   = 1'b0;
    w_k_dec   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ena) begin
          w_sel_nxt = OP_INIT;
          w_err_nxt = 1'b0;
          w_k_clr   = 1'b1;
        end
      end
      ST_DECIDE: begin
        if (!v_is_one) begin
          if (w_k_max) begin
            w_err_nxt = 1'b1;
          end else begin
            w_k_inc = 1'b1;
            if (u_is_even)      w_sel_nxt = OP_SHR_U;
            else if (v_is_even) w_sel_nxt = OP_SHR_V;
            else if (u_gt_v)    w_sel_nxt = OP_SUB_UV;
            else                w_sel_nxt = OP_SUB_VU;
          end
        end
      end
      ST_RED_DECIDE: begin
        if (!w_k_zero) begin
          w_sel_nxt = OP_REDUCE;
          w_k_dec   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdy <= 1'b1;
      r_err <= 1'b0;
      r_ena <= 1'b0;
      r_sel <= OP_INIT;
    end else begin
      r_rdy <= (w_state_nxt == ST_IDLE);
      r_err <= w_err_nxt;
      r_ena <= (w_state_nxt == ST_ISSUE);
      r_sel <= w_sel_nxt;
    end
  end

  assign rdy        = r_rdy;
  assign err        = r_err;
  assign helper_ena = r_ena;
  assign helper_sel = r_sel;
  assign k_is_nul   = w_k_zero;

`ifdef MODINV_SCHED_PERF_EN
  logic [31:0] r_perf_cycles;
  logic [15:0] r_perf_ops;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_cycles <= '0;
      r_perf_ops    <= '0;
    end else if (w_start) begin
      r_perf_cycles <= '0;
      r_perf_ops    <= '0;
    end else begin
      if (!r_rdy && (r_perf_cycles != '1)) r_perf_cycles <= r_perf_cycles + 1'b1;
      if (r_ena)                           r_perf_ops    <= r_perf_ops + 1'b1;
    end
  end

  assign perf_cycles = r_perf_cycles;
  assign perf_ops    = r_perf_ops;
`else
  logic w_unused;
  assign w_unused = w_start;
`endif

endmodule

// File: tb/tb_modinv_helper_scheduler.sv
// Scoreboard bench for modinv_helper_scheduler with a fixed-latency helper model and scripted flags.
module tb_modinv_helper_scheduler;
  import modinv_sched_pkg::*;

  localparam int N_LAT = 12;
  localparam int KW    = 10;

  typedef struct packed {
    logic [2:0]    sel;
    logic [KW-1:0] k;
    logic          nul;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ena;
  logic          rdy;
  logic          err;
  logic          u_is_even;
  logic          v_is_even;
  logic          u_gt_v;
  logic          v_is_one;
  logic          helper_ena;
  logic [2:0]    helper_sel;
  logic          helper_rdy;
  logic [KW-1:0] k_cnt;
  logic          k_is_nul;
`ifdef MODINV_SCHED_PERF_EN
  logic [31:0]   perf_cycles;
  logic [15:0]   perf_ops;
`endif

  always #5 clk = ~clk;

  modinv_helper_scheduler #(.OPERAND_NUM_BITS(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .rdy        (rdy),
    .err        (err),
    .u_is_even  (u_is_even),
    .v_is_even  (v_is_even),
    .u_gt_v     (u_gt_v),
    .v_is_one   (v_is_one),
    .helper_ena (helper_ena),
    .helper_sel (helper_sel),
    .helper_rdy (helper_rdy),
    .k_cnt      (k_cnt),
    .k_is_nul   (k_is_nul)
`ifdef MODINV_SCHED_PERF_EN
    ,
    .perf_cycles(perf_cycles),
    .perf_ops   (perf_ops)
`endif
  );

  int         checks = 0;
  int         errors = 0;
  exp_t       sb[$];
  logic [3:0] fq[$];   // {u_even, v_even, u_gt_v, v_one} per completed op
  logic [3:0] fdef;
  int         ops;
  int         busy_cyc;
  int         hcnt;
  bit         launch;
  logic       prev_ena;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [2:0] sel, input int k, input logic nul);
    exp_t e;
    e.sel = sel;
    e.k   = KW'(k);
    e.nul = nul;
    return e;
  endfunction

  // Helper model and scoreboard monitor, sampled 1 time unit after the active edge.
  always @(posedge clk) begin
    logic [3:0] f;
    exp_t       e;
    #1;
    if (launch) begin
      helper_rdy = 1'b0;
      hcnt       = N_LAT;
      launch     = 1'b0;
    end else if (hcnt > 0) begin
      hcnt--;
      if (hcnt == 0) begin
        helper_rdy = 1'b1;
        f = (fq.size() > 0) ? fq.pop_front() : fdef;
        {u_is_even, v_is_even, u_gt_v, v_is_one} = f;
      end
    end
    if (!rdy) busy_cyc++;
    if (helper_ena) begin
      launch = 1'b1;
      ops++;
      check("ena_width", 32'(prev_ena), 0);
      check("issue_while_busy", 32'(helper_rdy), 1);
      check("sb_underflow", 32'(sb.size() == 0), 0);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("sel", 32'(helper_sel), 32'(e.sel));
        check("k_at_issue", 32'(k_cnt), 32'(e.k));
        check("k_is_nul", 32'(k_is_nul), 32'(e.nul));
      end
    end
    prev_ena = helper_ena;
  end

  task automatic start();
    @(negedge clk);
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (rdy !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({"done_", tag}, 32'(rdy), 1);
  endtask

  task automatic wait_helper_idle();
    int n = 0;
    while (!(helper_rdy && hcnt == 0 && !launch) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("helper_idle", 32'(helper_rdy), 1);
  endtask

  task automatic run_loop_mix();
    fq = '{4'b1000, 4'b0100, 4'b0010, 4'b0000, 4'b0001};
    fdef = 4'b0000;
    sb.push_back(mk(3'(OP_INIT),   0, 1'b1));
    sb.push_back(mk(3'(OP_SHR_U),  1, 1'b0));
    sb.push_back(mk(3'(OP_SHR_V),  2, 1'b0));
    sb.push_back(mk(3'(OP_SUB_UV), 3, 1'b0));
    sb.push_back(mk(3'(OP_SUB_VU), 4, 1'b0));
    sb.push_back(mk(3'(OP_REDUCE), 3, 1'b0));
    sb.push_back(mk(3'(OP_REDUCE), 2, 1'b0));
    sb.push_back(mk(3'(OP_REDUCE), 1, 1'b0));
    sb.push_back(mk(3'(OP_REDUCE), 0, 1'b1));
    ops      = 0;
    busy_cyc = 0;
    start();
    wait_done("mix", 1000);
    check("mix_ops", ops, 9);
    check("mix_k", 32'(k_cnt), 0);
    check("mix_err", 32'(err), 0);
    check("mix_sb_left", sb.size(), 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; ena = 1'b0;
    {u_is_even, v_is_even, u_gt_v, v_is_one} = 4'b0000;
    helper_rdy = 1'b1; hcnt = 0; launch = 1'b0; ops = 0; busy_cyc = 0;
    prev_ena = 1'b0; fdef = 4'b0000;
    repeat (3) @(negedge clk);
    check("rst_rdy", 32'(rdy), 1);
    check("rst_err", 32'(err), 0);
    check("rst_ena", 32'(helper_ena), 0);
    check("rst_sel", 32'(helper_sel), 0);
    check("rst_k", 32'(k_cnt), 0);
    check("rst_nul", 32'(k_is_nul), 1);
    rst_n = 1'b1;

    // Reset in the middle of WAIT
    fdef = 4'b1000;
    sb.push_back(mk(3'(OP_INIT),  0, 1'b1));
    sb.push_back(mk(3'(OP_SHR_U), 1, 1'b0));
    ops = 0;
    start();
    n = 0;
    while (ops < 2 && n < 200) begin @(negedge clk); n++; end
    check("midrst_ops", ops, 2);
    repeat (3) @(negedge clk);
    check("midrst_busy", 32'(rdy), 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_rdy", 32'(rdy), 1);
    check("midrst_ena", 32'(helper_ena), 0);
    check("midrst_k", 32'(k_cnt), 0);
    check("midrst_err", 32'(err), 0);
    wait_helper_idle();
    repeat (4) @(negedge clk);
    check("midrst_stay_idle", 32'(rdy), 1);
    check("midrst_no_issue", ops, 2);
    check("midrst_sb_left", sb.size(), 0);

    // v_is_one right after INIT
    fq = '{4'b0001};
    fdef = 4'b0000;
    sb.push_back(mk(3'(OP_INIT), 0, 1'b1));
    ops = 0;
    start();
    wait_done("vone", 500);
    check("vone_ops", ops, 1);
    check("vone_k", 32'(k_cnt), 0);
    check("vone_err", 32'(err), 0);
    check("vone_sb_left", sb.size(), 0);

    // Every loop op once, then four reduces
    run_loop_mix();

    // Never converges: iteration bound
    fq.delete();
    fdef = 4'b1000;
    sb.push_back(mk(3'(OP_INIT), 0, 1'b1));
    for (int i = 1; i <= MAX_ITER; i++) sb.push_back(mk(3'(OP_SHR_U), i, 1'b0));
    ops = 0;
    start();
    wait_done("maxit", 20000);
    check("maxit_ops", ops, MAX_ITER + 1);
    check("maxit_err", 32'(err), 1);
    check("maxit_k", 32'(k_cnt), MAX_ITER);
    check("maxit_sb_left", sb.size(), 0);

    // ena while busy is ignored
    fq = '{4'b1000, 4'b0001};
    fdef = 4'b0000;
    sb.push_back(mk(3'(OP_INIT),   0, 1'b1));
    sb.push_back(mk(3'(OP_SHR_U),  1, 1'b0));
    sb.push_back(mk(3'(OP_REDUCE), 0, 1'b1));
    ops = 0;
    start();
    check("restart_err_clr", 32'(err), 0);
    n = 0;
    while (helper_rdy !== 1'b0 && n < 50) begin @(negedge clk); n++; end
    check("busy_seen", 32'(helper_rdy), 0);
    ena = 1'b1;
    @(negedge clk);
    ena = 1'b0;
    wait_done("ign", 500);
    repeat (20) @(negedge clk);
    check("ign_ops", ops, 3);
    check("ign_rdy", 32'(rdy), 1);
    check("ign_k", 32'(k_cnt), 0);
    check("ign_sb_left", sb.size(), 0);

`ifdef MODINV_SCHED_PERF_EN
    run_loop_mix();
    check("perf_ops", 32'(perf_ops), 9);
    check("perf_cycles", perf_cycles, busy_cyc);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
